// File: rtl/mem_access.sv
// MEM stage of the pipeline: drives the data bus for loads/stores, aligns load data,
// and loads the MEM/WB register. Bus handshake: dmem_req held with stable payload until a one-cycle dmem_ack.
module mem_access #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] store_data_mem,
   input  logic [2:0]  funct3_mem,
   input  logic        memread_mem,
   input  logic        memwrite_mem,
   input  logic        regwrite_mem,
   input  logic [4:0]  rd_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_mem,
   output logic [31:0] wb_data_mem,
   output logic        fault_mem,
   output logic [4:0]  rd_wb,
   output logic        regwrite_wb,
   output logic [31:0] write_data_wb
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          tmo_flag;
   logic [31:0]   rdata_q;
   logic          mem_op, size_ok, f3_ok, legal, start, commit;
   logic [3:0]    be_next;
   logic [31:0]   wdata_next, lane, load_val;

   always_comb begin
      mem_op = valid_mem & (memread_mem | memwrite_mem);
      case (funct3_mem[1:0])
         2'b00:   size_ok = 1'b1;
         2'b01:   size_ok = ~alu_result_mem[0];
         2'b10:   size_ok = (alu_result_mem[1:0] == 2'b00);
         default: size_ok = 1'b0;
      endcase
      if (memread_mem)
         f3_ok = (funct3_mem[1:0] != 2'b11) && (funct3_mem[2:1] != 2'b11);
      else
         f3_ok = ~funct3_mem[2] && (funct3_mem[1:0] != 2'b11);
      legal = ~(memread_mem & memwrite_mem) & f3_ok & size_ok;
      // tmo_flag marks the cycle right after a timeout: the stuck instruction drains, no retry.
      start = rst & (state == IDLE) & mem_op & legal & ~tmo_flag;
      stall_mem = start | (state == REQ);
      fault_mem = rst & (((state == IDLE) & mem_op & ~legal) | tmo_flag);
      dmem_req = (state == REQ);
      wb_data_mem = alu_result_mem;

      case (funct3_mem[1:0])
         2'b00: begin
            be_next    = 4'b0001 << alu_result_mem[1:0];
            wdata_next = {4{store_data_mem[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << alu_result_mem[1:0];
            wdata_next = {2{store_data_mem[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = store_data_mem;
         end
      endcase

      lane = rdata_q >> {alu_result_mem[1:0], 3'b000};
      case (funct3_mem)
         3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_val = {24'd0, lane[7:0]};
         3'b101:  load_val = {16'd0, lane[15:0]};
         default: load_val = lane;
      endcase

      commit = valid_mem & ~tmo_flag & ((state == DONE) | ~(memread_mem | memwrite_mem));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         tmo_flag   <= 1'b0;
         rdata_q    <= '0;
         dmem_we    <= 1'b0;
         dmem_be    <= 4'b0000;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         tmo_flag <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state      <= REQ;
               cnt        <= '0;
               dmem_addr  <= {alu_result_mem[31:2], 2'b00};
               dmem_we    <= memwrite_mem;
               dmem_wdata <= wdata_next;
               dmem_be    <= be_next;
            end
            REQ: begin
               if (dmem_ack) begin
                  rdata_q <= dmem_rdata;
                  state   <= DONE;
                  dmem_we <= 1'b0;
                  dmem_be <= 4'b0000;
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  state    <= IDLE;
                  tmo_flag <= 1'b1;
                  dmem_we  <= 1'b0;
                  dmem_be  <= 4'b0000;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stalls, faults and bubbles all collapse into commit=0, so only regwrite needs gating.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_wb         <= 5'd0;
         regwrite_wb   <= 1'b0;
         write_data_wb <= '0;
      end else begin
         rd_wb         <= rd_mem;
         regwrite_wb   <= commit & regwrite_mem & ~memwrite_mem & (rd_mem != 5'd0);
         write_data_wb <= ((state == DONE) && memread_mem) ? load_val : alu_result_mem;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, loads, stores, illegal accesses,
// bus timeout and reset in the middle of a bus request.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_mem = 1'b0;
   logic [31:0] alu_result_mem = '0;
   logic [31:0] store_data_mem = '0;
   logic [2:0]  funct3_mem = '0;
   logic        memread_mem = 1'b0;
   logic        memwrite_mem = 1'b0;
   logic        regwrite_mem = 1'b0;
   logic [4:0]  rd_mem = '0;
   logic        dmem_req, dmem_we, stall_mem, fault_mem, regwrite_wb;
   logic [31:0] dmem_addr, dmem_wdata, wb_data_mem, write_data_wb;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic [4:0]  rd_wb;

   int errors = 0;
   int checks = 0;

   mem_access dut (
      .clk(clk), .rst(rst), .valid_mem(valid_mem), .alu_result_mem(alu_result_mem),
      .store_data_mem(store_data_mem), .funct3_mem(funct3_mem), .memread_mem(memread_mem),
      .memwrite_mem(memwrite_mem), .regwrite_mem(regwrite_mem), .rd_mem(rd_mem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
      .wb_data_mem(wb_data_mem), .fault_mem(fault_mem), .rd_wb(rd_wb),
      .regwrite_wb(regwrite_wb), .write_data_wb(write_data_wb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [2:0] f3, input logic mr, input logic mw,
                        input logic rw, input logic [4:0] rd);
      valid_mem = v; alu_result_mem = addr; store_data_mem = sdata; funct3_mem = f3;
      memread_mem = mr; memwrite_mem = mw; regwrite_mem = rw; rd_mem = rd;
   endtask

   task automatic bubble();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   // Load with ack in the first REQ cycle: IDLE, REQ, DONE, then MEM/WB holds the result.
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [31:0] exp);
      drive(1'b1, addr, 32'd0, f3, 1'b1, 1'b0, 1'b1, rd);
      #1 check({tag, "_stall_idle"}, 32'(stall_mem), 32'd1);
      next();
      check({tag, "_req"}, 32'(dmem_req), 32'd1);
      check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
      dmem_ack = 1'b1; dmem_rdata = rdata;
      #1 check({tag, "_stall_req"}, 32'(stall_mem), 32'd1);
      next();
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
      check({tag, "_stall_done"}, 32'(stall_mem), 32'd0);
      check({tag, "_req_done"}, 32'(dmem_req), 32'd0);
      next();
      check({tag, "_rd_wb"}, 32'(rd_wb), 32'(rd));
      check({tag, "_regwrite_wb"}, 32'(regwrite_wb), 32'd1);
      check({tag, "_data_wb"}, write_data_wb, exp);
      bubble();
   endtask

   task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [2:0] f3, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
      drive(1'b1, addr, sdata, f3, 1'b0, 1'b1, 1'b1, 5'd3);
      #1 check({tag, "_stall_idle"}, 32'(stall_mem), 32'd1);
      next();
      check({tag, "_req"}, 32'(dmem_req), 32'd1);
      check({tag, "_we"}, 32'(dmem_we), 32'd1);
      check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
      check({tag, "_wdata"}, dmem_wdata, exp_wdata);
      check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
      dmem_ack = 1'b1;
      next();
      dmem_ack = 1'b0;
      next();
      check({tag, "_regwrite_wb"}, 32'(regwrite_wb), 32'd0);
      bubble();
   endtask

   task automatic do_illegal(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic mr, input logic mw);
      drive(1'b1, addr, 32'h1111_2222, f3, mr, mw, 1'b1, 5'd9);
      #1;
      check({tag, "_fault"}, 32'(fault_mem), 32'd1);
      check({tag, "_stall"}, 32'(stall_mem), 32'd0);
      check({tag, "_req"}, 32'(dmem_req), 32'd0);
      next();
      check({tag, "_req_after"}, 32'(dmem_req), 32'd0);
      check({tag, "_regwrite_wb"}, 32'(regwrite_wb), 32'd0);
      bubble();
      #1 check({tag, "_fault_clear"}, 32'(fault_mem), 32'd0);
   endtask

   initial begin
      // Reset values
      drive(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 3'b010, 1'b1, 1'b0, 1'b1, 5'd1);
      #3;
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_stall", 32'(stall_mem), 32'd0);
      check("rst_fault", 32'(fault_mem), 32'd0);
      check("rst_be", 32'(dmem_be), 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      check("rst_regwrite_wb", 32'(regwrite_wb), 32'd0);
      check("rst_rd_wb", 32'(rd_wb), 32'd0);
      check("rst_data_wb", write_data_wb, 32'd0);
      bubble();
      next();
      rst = 1'b1;
      next();

      // ALU op passes straight through
      drive(1'b1, 32'h0000_1234, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd5);
      #1;
      check("add_stall", 32'(stall_mem), 32'd0);
      check("add_req", 32'(dmem_req), 32'd0);
      check("add_fwd", wb_data_mem, 32'h0000_1234);
      next();
      check("add_rd_wb", 32'(rd_wb), 32'd5);
      check("add_regwrite_wb", 32'(regwrite_wb), 32'd1);
      check("add_data_wb", write_data_wb, 32'h0000_1234);
      drive(1'b1, 32'h0000_0042, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0);
      next();
      check("x0_regwrite_wb", 32'(regwrite_wb), 32'd0);
      bubble();
      next();
      check("bubble_regwrite_wb", 32'(regwrite_wb), 32'd0);

      // LB 0x103, ack on the second REQ cycle; a stray ack in IDLE is ignored
      drive(1'b1, 32'h0000_0103, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd7);
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      #1 check("lb_stall_1", 32'(stall_mem), 32'd1);
      next();
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
      check("lb_req_1", 32'(dmem_req), 32'd1);
      check("lb_addr", dmem_addr, 32'h0000_0100);
      check("lb_we", 32'(dmem_we), 32'd0);
      check("lb_stall_2", 32'(stall_mem), 32'd1);
      next();
      check("lb_req_2", 32'(dmem_req), 32'd1);
      check("lb_addr_hold", dmem_addr, 32'h0000_0100);
      check("lb_bubble_wb", 32'(regwrite_wb), 32'd0);
      dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF00;
      #1 check("lb_stall_3", 32'(stall_mem), 32'd1);
      next();
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
      check("lb_stall_done", 32'(stall_mem), 32'd0);
      check("lb_req_done", 32'(dmem_req), 32'd0);
      next();
      check("lb_rd_wb", 32'(rd_wb), 32'd7);
      check("lb_regwrite_wb", 32'(regwrite_wb), 32'd1);
      check("lb_data_wb", write_data_wb, 32'hFFFF_FF80);
      bubble();

      do_load("lh", 32'h0000_0206, 3'b001, 32'h8001_1234, 5'd8, 32'hFFFF_8001);
      do_load("lhu", 32'h0000_0206, 3'b101, 32'h8001_1234, 5'd9, 32'h0000_8001);
      do_load("lbu", 32'h0000_0101, 3'b100, 32'h1234_80AB, 5'd10, 32'h0000_0080);
      do_load("lw", 32'h0000_0300, 3'b010, 32'hCAFE_F00D, 5'd11, 32'hCAFE_F00D);

      do_store("sh", 32'h0000_0202, 32'hABCD_5678, 3'b001, 4'b1100, 32'h5678_5678);
      do_store("sb", 32'h0000_0101, 32'h0000_00EF, 3'b000, 4'b0010, 32'hEFEF_EFEF);
      do_store("sw", 32'h0000_0400, 32'h1357_9BDF, 3'b010, 4'b1111, 32'h1357_9BDF);

      do_illegal("lw_mis", 32'h0000_0101, 3'b010, 1'b1, 1'b0);
      do_illegal("lh_mis", 32'h0000_0201, 3'b001, 1'b1, 1'b0);
      do_illegal("ld_f3", 32'h0000_0200, 3'b011, 1'b1, 1'b0);
      do_illegal("st_f3", 32'h0000_0200, 3'b100, 1'b0, 1'b1);
      do_illegal("rd_wr", 32'h0000_0200, 3'b010, 1'b1, 1'b1);

      // Timeout: no ack for 16 REQ cycles
      drive(1'b1, 32'h0000_0500, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd4);
      next();
      for (int i = 0; i < 16; i++) begin
         check("tmo_req_held", 32'(dmem_req), 32'd1);
         next();
      end
      check("tmo_req_drop", 32'(dmem_req), 32'd0);
      check("tmo_fault", 32'(fault_mem), 32'd1);
      check("tmo_stall", 32'(stall_mem), 32'd0);
      next();
      check("tmo_regwrite_wb", 32'(regwrite_wb), 32'd0);
      check("tmo_fault_clear", 32'(fault_mem), 32'd0);
      check("tmo_no_retry", 32'(dmem_req), 32'd0);
      bubble();
      next();

      // Reset in the middle of REQ, then a normal load
      drive(1'b1, 32'h0000_0600, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd6);
      next();
      check("mid_req", 32'(dmem_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_req", 32'(dmem_req), 32'd0);
      check("mid_rst_stall", 32'(stall_mem), 32'd0);
      check("mid_rst_fault", 32'(fault_mem), 32'd0);
      check("mid_rst_be", 32'(dmem_be), 32'd0);
      check("mid_rst_addr", dmem_addr, 32'd0);
      bubble();
      next();
      check("mid_rst_no_fault", 32'(fault_mem), 32'd0);
      rst = 1'b1;
      next();
      do_load("lw_after_rst", 32'h0000_0604, 3'b010, 32'h0BAD_CAFE, 5'd12, 32'h0BAD_CAFE);
      next();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
